// File: rtl/adder_beat_frontend.sv
// Narrow-bus front end for the wide combinational adder: gathers A, B and carry-in
// from BEAT-wide input beats, captures the sum, then streams it back out beat by beat.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  LOAD_A  | accept operand A beats (LSB first), carry-in taken on beat 0
//  LOAD_B  | accept operand B beats (LSB first)
//  CAPTURE | one cycle: register adder sum and carry-out
//  SEND    | emit result beats (LSB first); carry-out held for the phase
module adder_beat_frontend #(
  parameter int WIDTH = 128,
  parameter int BEAT  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BEAT-1:0]  in_data,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BEAT-1:0]  out_data,
  output logic             out_last,
  output logic             out_cout,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [15:0]      op_count
);

  localparam int BEATS = WIDTH / BEAT;
  localparam int IDXW  = $clog2(BEATS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BEATS - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              cin_q, cin_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              cout_q, cout_d;
  logic [15:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    res_d     = res_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_cout  = 1'b0;

    case (state_q)
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d[idx_q*BEAT +: BEAT] = in_data;
          if (idx_q == '0) cin_d = in_cin;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          b_d[idx_q*BEAT +: BEAT] = in_data;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = CAPTURE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      // Operands have been stable since the last B edge, so the adder output is settled.
      CAPTURE: begin
        res_d   = add_sum;
        cout_d  = add_cout;
        state_d = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = res_q[idx_q*BEAT +: BEAT];
        out_last  = (idx_q == LAST_IDX);
        out_cout  = cout_q;
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            cnt_d   = cnt_q + 16'd1;
            state_d = LOAD_A;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  assign add_a    = a_q;
  assign add_b    = b_q;
  assign add_cin  = cin_q;
  assign op_count = cnt_q;

endmodule
